// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle CPU's memory port and mem_responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory serving one load/store at a time; sub-word stores use
// read-modify-write, and every request ends in a one-cycle response pulse.
module mem_responder #(
    parameter int unsigned ADDR_W = 8
) (
    input logic            Clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StRmwWr, StDone} state_e;

    localparam logic [1:0] SzWord = 2'b00;
    localparam logic [1:0] SzByte = 2'b01;
    localparam logic [1:0] SzHalf = 2'b10;
    localparam logic [1:0] SzBad  = 2'b11;

    state_e              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [1:0]          size_q;
    logic [1:0]          lane_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rd_word_q;
    logic [31:0]         merge_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_err_q;

    logic [31:0]         mem_q [0:(1 << ADDR_W) - 1];

    logic                accept;
    logic                req_err;
    logic [ADDR_W-1:0]   req_idx;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_widx;
    logic [31:0]         mem_wdata;

    // Address bits above the word index wrap and are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SzByte:  return {24'h0, sh[7:0]};
            SzHalf:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        mask = ((size == SzByte) ? 32'h0000_00ff : 32'h0000_ffff) << {lane, 3'b000};
        return (old & ~mask) | ((wdata << {lane, 3'b000}) & mask);
    endfunction

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        accept  = bus.req_valid && (state_q == StIdle);
        req_idx = bus.req_addr[ADDR_W+1:2];
        req_err = (bus.req_size == SzBad) ||
                  (bus.req_size == SzHalf && bus.req_addr[0]) ||
                  (bus.req_size == SzWord && bus.req_addr[1:0] != 2'b00);

        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if (accept && !req_err && bus.req_wr && bus.req_size == SzWord) begin
            mem_we    = 1'b1;
            mem_widx  = req_idx;
            mem_wdata = bus.req_wdata;
        end else if (state_q == StRmwWr) begin
            mem_we    = 1'b1;
            mem_widx  = idx_q;
            mem_wdata = merge_q;
        end
        // Never write while reset is held, so an interrupted merge is dropped.
        mem_we = mem_we && reset;
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            size_q      <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            rd_word_q   <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    if (accept) begin
                        idx_q   <= req_idx;
                        size_q  <= bus.req_size;
                        lane_q  <= bus.req_addr[1:0];
                        wdata_q <= bus.req_wdata;
                        if (req_err) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (bus.req_wr && bus.req_size != SzWord) begin
                            rd_word_q <= mem_q[req_idx];
                            state_q   <= StRmwRd;
                        end else if (bus.req_wr) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            rd_word_q   <= mem_q[req_idx];
                            rsp_rdata_q <= load_lane(mem_q[req_idx], bus.req_size,
                                                     bus.req_addr[1:0]);
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    state_q     <= StDone;
                    rsp_valid_q <= 1'b1;
                end
                StRmwRd: begin
                    merge_q <= merge_lane(rd_word_q, wdata_q, size_q, lane_q);
                    state_q <= StRmwWr;
                end
                StRmwWr: begin
                    state_q     <= StDone;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                StDone: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, reset/hold corner sequences, then
// random traffic against a byte-addressed reference memory.
module tb_mem_responder;

    logic Clk;
    logic reset;
    int   checks;
    int   errors;

    mem_responder_if bus();

    mem_responder #(.ADDR_W(8)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [15];

    // Reference: 1 KiB little-endian byte store (ADDR_W = 8 wraps at 1024 bytes).
    logic [7:0] model_mem [1024];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_op(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat);
        int a;
        int n;
        a     = int'(addr % 1024);
        err   = (size == 2'd3) || (size == 2'd2 && addr % 2 != 0) ||
                (size == 2'd0 && addr % 4 != 0);
        rdata = 0;
        lat   = 1;
        if (!err) begin
            n = (size == 2'd0) ? 4 : (size == 2'd1) ? 1 : 2;
            if (wr) begin
                for (int k = 0; k < n; k++) model_mem[a + k] = 8'(wdata >> (8 * k));
                lat = (n == 4) ? 1 : 3;
            end else begin
                for (int k = 0; k < n; k++) rdata = rdata | (32'(model_mem[a + k]) << (8 * k));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_xact(input string name, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int          lat;
        logic [31:0] rdata;
        logic        err;
        chk({name, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge Clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat   = 0;
        rdata = 0;
        err   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (bus.rsp_valid) begin
                lat   = i;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
        chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({name, ".rdata"}, rdata, exp_rdata);
        chk({name, ".err"}, 32'(err), 32'(exp_err));
        @(negedge Clk);
        chk({name, ".pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          accepts;
        int          accept_at;
        int          pulses;
        logic [31:0] last_rdata;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 2'd0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1};
        vecs[1]  = '{1'b0, 2'd0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1};
        vecs[2]  = '{1'b1, 2'd1, 32'h012, 32'h00000055, 32'h0,        1'b0, 3};
        vecs[3]  = '{1'b0, 2'd0, 32'h010, 32'h0,        32'hDE55BEEF, 1'b0, 1};
        vecs[4]  = '{1'b1, 2'd2, 32'h010, 32'h00001234, 32'h0,        1'b0, 3};
        vecs[5]  = '{1'b0, 2'd2, 32'h010, 32'h0,        32'h00001234, 1'b0, 1};
        vecs[6]  = '{1'b0, 2'd1, 32'h013, 32'h0,        32'h000000DE, 1'b0, 1};
        vecs[7]  = '{1'b1, 2'd0, 32'h00C, 32'h01020304, 32'h0,        1'b0, 1};
        vecs[8]  = '{1'b0, 2'd2, 32'h011, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b1, 2'd0, 32'h00E, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
        vecs[10] = '{1'b1, 2'd3, 32'h00C, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
        vecs[11] = '{1'b0, 2'd0, 32'h00C, 32'h0,        32'h01020304, 1'b0, 1};
        vecs[12] = '{1'b1, 2'd0, 32'h400, 32'hCAFEF00D, 32'h0,        1'b0, 1};
        vecs[13] = '{1'b0, 2'd0, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0, 1};
        vecs[14] = '{1'b0, 2'd0, 32'h010, 32'h0,        32'hDE551234, 1'b0, 1};

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge Clk);
        chk("reset.ready", 32'(bus.req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 15; i++) begin
            run_xact($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].addr,
                     vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].lat);
        end

        // Reset pulsed while a byte store sits in RMW_RD: merge must be dropped.
        run_xact("rst_pre", 1'b1, 2'd0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_size  = 2'd1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h000000AA;
        @(posedge Clk);
        #1 bus.req_valid = 1'b0;
        @(negedge Clk);
        reset = 1'b0;
        #1;
        chk("rst_mid.ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mid.rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        run_xact("rst_post", 1'b0, 2'd0, 32'h20, 32'h0, 32'h11223344, 1'b0, 1);

        // A load held valid through a byte store's busy period is taken once, on return to idle.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_size  = 2'd1;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h00000077;
        @(posedge Clk);
        #1;
        bus.req_wr    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h20;
        accepts    = 0;
        accept_at  = 0;
        pulses     = 0;
        last_rdata = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (bus.rsp_valid) begin
                pulses++;
                last_rdata = bus.rsp_rdata;
            end
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                accept_at = i;
                @(posedge Clk);
                #1 bus.req_valid = 1'b0;
            end
        end
        chk("hold.accepts", 32'(accepts), 32'd1);
        chk("hold.accept_cycle", 32'(accept_at), 32'd4);
        chk("hold.pulses", 32'(pulses), 32'd2);
        chk("hold.rdata", last_rdata, 32'h11227744);

        // Fill every word so the reference and the array agree, then random traffic.
        for (int w = 0; w < 256; w++) begin
            addr  = 32'(w * 4) | ($urandom & 32'hFFFF_FC00);
            wdata = $urandom;
            model_op(1'b1, 2'd0, addr, wdata, exp_rdata, exp_err, exp_lat);
            run_xact($sformatf("fill%0d", w), 1'b1, 2'd0, addr, wdata, exp_rdata, exp_err,
                     exp_lat);
        end
        for (int n = 0; n < 400; n++) begin
            wr    = 1'($urandom);
            size  = 2'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            model_op(wr, size, addr, wdata, exp_rdata, exp_err, exp_lat);
            run_xact($sformatf("rnd%0d", n), wr, size, addr, wdata, exp_rdata, exp_err,
                     exp_lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
